// File: rtl/axi_defs_pkg.sv
// Shared AXI encodings, FSM state type and burst legality check for the burst RAM slave.
package axi_defs_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {IDLE, RD, WR, BR} state_e;

  // Bursts we cannot serve still run their full beat count, but answer SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (size != SIZE_4B) || ((burst == BURST_WRAP) && !wrap_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word index for FIXED/INCR/WRAP bursts; shared by the read and write paths.
module axi_burst_addr_gen
  import axi_defs_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic [MEM_AW-1:0] cur_idx,
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  output logic [MEM_AW-1:0] nxt_idx
);

  logic [MEM_AW-1:0] inc_idx;
  logic [MEM_AW-1:0] wrap_mask;
  logic              unused_len;

  // Legal WRAP lengths are 2^n-1, so len itself is the in-block offset mask.
  assign unused_len = ^len[7:4];

  always_comb begin
    inc_idx         = cur_idx + {{(MEM_AW-1){1'b0}}, 1'b1};
    wrap_mask       = '0;
    wrap_mask[3:0]  = len[3:0];
    nxt_idx         = inc_idx;
    case (burst)
      BURST_FIXED: nxt_idx = cur_idx;
      BURST_WRAP:  nxt_idx = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
      default:     nxt_idx = inc_idx;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram_slave.sv
// AXI3 burst slave over a word-addressed RAM, one transaction at a time.
// Build option AXI_SLAVE_RAND_STALL_EN adds LFSR-driven ready/valid stalls.
//
// state | meaning
// IDLE  | ready for AR or AW; a read wins when both are valid
// RD    | streaming read beats, rlast on beat len
// WR    | accepting W beats into RAM
// BR    | holding the write response until bready
module axi_burst_ram_slave
  import axi_defs_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0]       mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d, nxt_idx, rd_idx;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d, wl_err_q, wl_err_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]       rdata_q, rdata_d, rd_word;
  logic [1:0]        rresp_q, rresp_d, bresp_q, bresp_d;
  logic              bvalid_q, bvalid_d;
  logic              mem_we, stall, ar_hs, aw_hs, w_hs, r_hs, w_end, ar_err, aw_err, wl_bad;
  logic              unused_bits;

  assign unused_bits = ^{wid, araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  axi_burst_addr_gen #(.MEM_AW(MEM_AW)) u_addr_gen (
    .cur_idx (addr_q),
    .burst   (burst_q),
    .len     (len_q),
    .nxt_idx (nxt_idx)
  );

  assign arready = (state_q == IDLE) && !rst && !stall;
  assign awready = (state_q == IDLE) && !arvalid && !rst && !stall;
  assign wready  = (state_q == WR) && !rst && !stall;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign r_hs    = rvalid_q && rready;
  assign w_end   = (cnt_q == len_q);
  assign wl_bad  = (wlast != w_end);
  assign ar_err  = burst_err(arburst, arsize, arlen);
  assign aw_err  = burst_err(awburst, awsize, awlen);
  assign rd_idx  = (state_q == IDLE) ? araddr[MEM_AW+1:2] : nxt_idx;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    err_d    = err_q;
    wl_err_d = wl_err_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d  = RD;
          id_d     = arid;
          addr_d   = araddr[MEM_AW+1:2];
          len_d    = arlen;
          burst_d  = arburst;
          cnt_d    = 8'd0;
          err_d    = ar_err;
          rvalid_d = 1'b1;
          rlast_d  = (arlen == 8'd0);
          rresp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d  = ar_err ? 32'd0 : rd_word;
        end else if (aw_hs) begin
          state_d  = WR;
          id_d     = awid;
          addr_d   = awaddr[MEM_AW+1:2];
          len_d    = awlen;
          burst_d  = awburst;
          cnt_d    = 8'd0;
          err_d    = aw_err;
          wl_err_d = 1'b0;
        end
      end
      RD: begin
        // A stalled next beat leaves rvalid low until the stall clears.
        if (r_hs && rlast_q) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end else if ((r_hs || !rvalid_q) && !stall) begin
          addr_d   = nxt_idx;
          cnt_d    = cnt_q + 8'd1;
          rvalid_d = 1'b1;
          rlast_d  = ((cnt_q + 8'd1) == len_q);
          rdata_d  = err_q ? 32'd0 : rd_word;
        end else if (r_hs) begin
          rvalid_d = 1'b0;
        end
      end
      WR: begin
        if (w_hs) begin
          mem_we   = !err_q;
          wl_err_d = wl_err_q || wl_bad;
          if (w_end) begin
            state_d  = BR;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || wl_err_q || wl_bad) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = nxt_idx;
          end
        end
      end
      BR: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      wl_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      wl_err_q <= wl_err_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[addr_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rid    = id_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;
  assign bid    = id_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Scoreboard bench for axi_burst_ram_slave: expected beats/responses queued at issue, checked on handshake.
module tb_axi_burst_ram_slave;
  import axi_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_burst_ram_slave #(.MEM_AW(12), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model [4096];
  int          n_vec = 0;
  int          n_err = 0;
  time         rd_last_t, aw_hs_t;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit berr(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    return (b == 2'b11) || (s != 3'b010) ||
           ((b == 2'b10) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  function automatic int widx(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input int k);
    int start, blk, base;
    start = int'(a[13:2]);
    blk   = int'(l) + 1;
    case (b)
      2'b00:   return start;
      2'b10: begin
        base = start - (start % blk);
        return base + ((start - base + k) % blk);
      end
      default: return (start + k) % 4096;
    endcase
  endfunction

  // Starts and ends just after a rising edge.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input bit toggle,
                          input int abort_at);
    bit          e, held, got_last;
    int          hs, cyc, n;
    logic [31:0] held_data;
    rbeat_t      x;
    e = berr(burst, size, len);
    for (int k = 0; k <= int'(len); k++) begin
      x.data = e ? 32'd0 : model[widx(addr, len, burst, k)];
      x.resp = e ? 2'b10 : 2'b00;
      x.last = (k == int'(len));
      x.id   = id;
      rq.push_back(x);
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    chk("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = !toggle;
    hs = 0; cyc = 0; held = 0;
    while (hs <= int'(len) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      got_last = 0;
      chk("rvalid", 32'(rvalid), 32'd1);
      if (held) chk("r_hold", rdata, held_data);
      held = 0;
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("rq_depth", 32'(rq.size()), 32'd1);
        else begin
          x = rq.pop_front();
          chk("rdata", rdata, x.data);
          chk("rresp", 32'(rresp), 32'(x.resp));
          chk("rlast", 32'(rlast), 32'(x.last));
          chk("rid", 32'(rid), 32'(x.id));
          got_last = x.last;
        end
        last_rdata = rdata;
        hs++;
      end else if (rvalid) begin
        held = 1;
        held_data = rdata;
      end
      @(posedge clk);
      if (got_last) rd_last_t = $time;
      #1;
      if (abort_at > 0 && hs == abort_at) begin
        rready = 1'b0;
        return;
      end
      if (toggle) rready = ~rready;
    end
    if (hs <= int'(len)) chk("r_beats", 32'(hs), 32'(int'(len) + 1));
    rready = 1'b0;
    @(negedge clk);
    chk("rvalid_end", 32'(rvalid), 32'd0);
    chk("arready_idle", 32'(arready), 32'd1);
    @(posedge clk); #1;
  endtask

  // early_at < 0: wlast on the final beat; otherwise wlast only on beat early_at.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [31:0] dmul, input logic [31:0] dadd,
                           input int strb_beat, input logic [3:0] strb_val, input int early_at);
    bit          e, wl_bad, wl;
    int          n, idx;
    logic [31:0] d;
    logic [3:0]  s;
    bexp_t       be;
    e = berr(burst, size, len);
    wl_bad = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 400);
    chk("awready", 32'(awready), 32'd1);
    @(posedge clk);
    aw_hs_t = $time;
    #1;
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      d  = dmul * 32'(k) + dadd;
      s  = (k == strb_beat) ? strb_val : 4'hF;
      wl = (early_at >= 0) ? (k == early_at) : (k == int'(len));
      if (wl != (k == int'(len))) wl_bad = 1;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = wl; wid = id;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      chk("wready", 32'(wready), 32'd1);
      @(posedge clk); #1;
      if (!e) begin
        idx = widx(addr, len, burst, k);
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    be.resp = (e || wl_bad) ? 2'b10 : 2'b00;
    be.id   = id;
    bq.push_back(be);
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    chk("bvalid", 32'(bvalid), 32'd1);
    be = bq.pop_front();
    chk("bresp", 32'(bresp), 32'(be.resp));
    chk("bid", 32'(bid), 32'(be.id));
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("bvalid_end", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    rd_last_t = 0; aw_hs_t = 0; last_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_wready", 32'(wready), 32'd0);
    @(posedge clk); #1;

    // Preload and INCR read of an 8-beat line.
    axi_write(4'h1, 32'h400, 8'd7, BURST_INCR, SIZE_4B, 32'd1, 32'hA0, -1, 4'hF, -1);
    axi_read(4'h5, 32'h400, 8'd7, BURST_INCR, SIZE_4B, 0, 0);
    chk("incr_last_word", last_rdata, 32'hA7);

    // Byte strobes on beat 2 merge into the previous contents.
    axi_write(4'h1, 32'h800, 8'd7, BURST_INCR, SIZE_4B, 32'd1, 32'hCAFE_0000, -1, 4'hF, -1);
    axi_write(4'h2, 32'h800, 8'd7, BURST_INCR, SIZE_4B, 32'h1111_1111, 32'd0, 2, 4'b0101, -1);
    axi_read(4'h2, 32'h808, 8'd0, BURST_FIXED, SIZE_4B, 0, 0);
    chk("strb_word", last_rdata, 32'hCA22_0022);

    // WRAP read 0x106,0x107,0x104,0x105; FIXED repeats one word.
    axi_read(4'h6, 32'h418, 8'd3, BURST_WRAP, SIZE_4B, 0, 0);
    chk("wrap_last_word", last_rdata, 32'hA5);
    axi_read(4'h7, 32'h404, 8'd2, BURST_FIXED, SIZE_4B, 0, 0);

    // WRAP write inside an aligned 8-word block, checked by a linear read.
    axi_write(4'h3, 32'h61C, 8'd7, BURST_WRAP, SIZE_4B, 32'd3, 32'h6600_0000, -1, 4'hF, -1);
    axi_read(4'h3, 32'h600, 8'd7, BURST_INCR, SIZE_4B, 0, 0);

    // INCR rolls over the RAM end; upper address bits alias.
    axi_write(4'h8, 32'h3FF8, 8'd3, BURST_INCR, SIZE_4B, 32'd1, 32'hBB00_0000, -1, 4'hF, -1);
    axi_read(4'h8, 32'h3FF8, 8'd3, BURST_INCR, SIZE_4B, 0, 0);
    axi_read(4'h9, 32'h0001_0400, 8'd0, BURST_INCR, SIZE_4B, 0, 0);
    chk("alias_word", last_rdata, 32'hA0);

    // Simultaneous AR and AW: the read is served first.
    fork
      axi_read(4'h3, 32'h400, 8'd7, BURST_INCR, SIZE_4B, 0, 0);
      axi_write(4'h9, 32'hC00, 8'd3, BURST_INCR, SIZE_4B, 32'h10, 32'h5000_0000, -1, 4'hF, -1);
    join
    chk("read_before_write", 32'(aw_hs_t > rd_last_t), 32'd1);
    axi_read(4'hA, 32'hC00, 8'd3, BURST_INCR, SIZE_4B, 0, 0);

    // Error responses.
    axi_read(4'hB, 32'h400, 8'd3, 2'b11, SIZE_4B, 0, 0);
    axi_read(4'hB, 32'h400, 8'd2, BURST_WRAP, SIZE_4B, 0, 0);
    axi_read(4'hC, 32'h400, 8'd1, BURST_INCR, 3'b011, 0, 0);
    axi_write(4'h4, 32'hD00, 8'd3, BURST_INCR, SIZE_4B, 32'd1, 32'h7700_0000, -1, 4'hF, 1);
    axi_read(4'h4, 32'hD00, 8'd3, BURST_INCR, SIZE_4B, 0, 0);
    axi_write(4'h4, 32'hD40, 8'd1, BURST_INCR, SIZE_4B, 32'd1, 32'h7800_0000, -1, 4'hF, 99);
    axi_write(4'hD, 32'hE00, 8'd1, BURST_INCR, SIZE_4B, 32'd1, 32'hEE00_0000, -1, 4'hF, -1);
    axi_write(4'hD, 32'hE00, 8'd1, BURST_INCR, 3'b011, 32'd1, 32'h1234_0000, -1, 4'hF, -1);
    axi_read(4'hD, 32'hE00, 8'd1, BURST_INCR, SIZE_4B, 0, 0);
    chk("size_err_nowrite", last_rdata, 32'hEE00_0001);

    // rready toggling, then reset after the third beat.
    axi_read(4'hE, 32'h400, 8'd7, BURST_INCR, SIZE_4B, 1, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
    axi_read(4'hF, 32'h400, 8'd7, BURST_INCR, SIZE_4B, 0, 0);
    chk("post_reset_last", last_rdata, 32'hA7);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram_slave.md
Name: axi_burst_ram_slave

Overview:
- AXI3-style slave (32-bit data) with a word-addressed internal RAM; the responder end of the cache-line burst master used by the I/D-cache AXI bridge.
- Serves INCR/FIXED/WRAP read and write bursts, one transaction at a time.
- Used as the bench/SoC-side memory model so the CPU's 8-beat line refills and write-backs can be exercised without the external AXI crossbar.

Parameters:
- MEM_AW, 12, log2 of RAM depth in 32-bit words (default 4096 words = 16 KiB).
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- arid in ID_W; araddr in 32; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1
- rid out ID_W; rdata out 32; rresp out 2; rlast out 1; rvalid out 1; rready in 1
- awid in ID_W; awaddr in 32; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1
- wid in ID_W; wdata in 32; wstrb in 4; wlast in 1; wvalid in 1; wready out 1
- bid out ID_W; bresp out 2; bvalid out 1; bready in 1

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: FSM to IDLE. arready=0, awready=0, wready=0, rvalid=0, rlast=0, bvalid=0, rresp=0, bresp=0, rid=0, bid=0, rdata=0. RAM contents are not cleared.
- FSM states and transitions:
  - IDLE: arready=1, awready=1. If arvalid, accept the read and go to RD; a read wins when arvalid and awvalid are both high, and awready drops that cycle. Else if awvalid, accept the write and go to WR.
  - RD: first rvalid one cycle after the AR handshake, rdata registered from RAM. Each beat holds stable until rready. Next beat is presented the cycle after a handshake (full throughput when rready is held high). rlast=1 on beat arlen. After the last handshake, return to IDLE; arready reasserts the next cycle.
  - WR: wready=1. Each W handshake writes bytes selected by wstrb to the current word, then advances the address. The beat with count==awlen goes to BR.
  - BR: bvalid=1, bid=awid latched. Return to IDLE on bready.
- Address rules:
  - Word index = addr[MEM_AW+1:2]. Higher address bits are ignored, so access aliases modulo the RAM size. addr[1:0] are ignored.
  - FIXED (00): address held for every beat.
  - INCR (01): +1 word per beat; wraps at the RAM end.
  - WRAP (10): wraps within an aligned (len+1)-word block; legal len is 1, 3, 7 or 15.
- Response codes:
  - rresp/bresp = OKAY (00).
  - SLVERR (10) on: burst type 11; arsize/awsize != 3'b010; WRAP with illegal len. The burst still completes with the full beat count; on reads rdata=0 for every beat, on writes the RAM is not written.
  - wlast mismatch (wlast=1 before beat awlen, or wlast=0 on beat awlen) forces bresp=SLVERR. The beat count still governs termination.
- IDs: rid = latched arid. wid is not checked.
- Reset mid-burst abandons the transaction; outputs take reset values the next cycle.
- Max burst 256 beats (8-bit len).

Optional Feature:
- Macro: AXI_SLAVE_RAND_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reloaded on rst) gates arready, awready, wready and new-beat rvalid.
  - Each is suppressed in a cycle when lfsr[1:0]==2'b00.
  - rvalid, once asserted, is never withdrawn before its handshake.
  - Data and ordering are unchanged.
- Undefined: no stalls, timing exactly as above.

Decomposition:
- Package axi_defs_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP;
  - resp constants RESP_OKAY/SLVERR;
  - SIZE_4B = 3'b010;
  - the FSM state enum {IDLE, RD, WR, BR}.
- Sub-module axi_burst_addr_gen: combinational next-word-index from current index, burst type and len. It is shared by the read and write paths.

Test Plan:
- INCR read: preload words 0x100..0x107 = 0xA0..0xA7; araddr=0x400, arlen=7, rready=1 -> 8 beats 0xA0..0xA7 back-to-back, rlast only on the 8th, rresp=00, rid=arid.
- Write with strobes: awaddr=0x800, awlen=7, beat k wdata=0x1111_1111*k, wstrb=4'b0101 on beat 2 -> bresp=00, bid=awid. Readback word 0x202 equals old value with bytes 0 and 2 replaced.
- WRAP: araddr=0x418, arlen=3, WRAP -> word order 0x106, 0x107, 0x104, 0x105.
- Simultaneous arvalid and awvalid in IDLE -> read served first, awready=0 until the read's rlast handshake completes. The write then completes correctly.
- Errors: arburst=11 -> 4 beats of rdata=0, rresp=10. Write with early wlast on beat 1 of len=3 -> bresp=10 after 4 beats.
- rready toggling every other cycle mid-burst, then rst asserted at beat 3 -> rdata held stable while stalled; all outputs at reset values one cycle after rst; a new burst then works.
